// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- UART baud tick generator.
//
// Produces a one-cycle oversample strobe (tick16_o), a bit strobe (tick_o,
// once per OVERSAMPLE oversample strobes) and a mid-bit strobe (mid_o).
// The divisor is programmable at runtime through a shadow register. A new
// divisor takes effect at the next period boundary, at any disabled cycle,
// or at a resync, whichever comes first.
//
// Optional feature macro: UART_BAUD_FRAC_EN
//   defined   : fractional accumulator present. Over 2^FRAC_W periods the
//               total is 2^FRAC_W*N + F cycles.
//   undefined : period is always the integer divisor. div_frac_i and
//               DEFAULT_FRAC are ignored. The port list is unchanged.
//
// Ports:
//   clk_i       clock
//   rstb_i      asynchronous active-low reset
//   en_i        count enable; low freezes counters
//   div_int_i   new integer divisor N (values below 2 are clamped to 2)
//   div_frac_i  new fractional divisor F, in units of 1/2^FRAC_W cycle
//   div_load_i  one-cycle request to capture div_int_i/div_frac_i
//   resync_i    restart phase; clears all counters
//   div_ack_o   pulse in the cycle a new divisor becomes active
//   tick16_o    oversample strobe
//   tick_o      bit strobe
//   mid_o       mid-bit strobe
module uart_baud_gen #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVERSAMPLE   = 16,
   parameter int DEFAULT_INT  = 814,
   parameter int DEFAULT_FRAC = 0
) (
   input  logic              clk_i,
   input  logic              rstb_i,
   input  logic              en_i,
   input  logic [DIV_W-1:0]  div_int_i,
   input  logic [FRAC_W-1:0] div_frac_i,
   input  logic              div_load_i,
   input  logic              resync_i,
   output logic              div_ack_o,
   output logic              tick16_o,
   output logic              tick_o,
   output logic              mid_o
);

   localparam int PW    = DIV_W + 1;
   localparam int SUB_W = $clog2(OVERSAMPLE);
   localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

   // Periods shorter than two cycles would make tick16_o stick high.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
      logic [DIV_W-1:0] r;
      if (n < DIV_W'(2)) begin
         r = DIV_W'(2);
      end else begin
         r = n;
      end
      return r;
   endfunction

   logic [DIV_W-1:0]  cnt_r, cnt_nxt_s;
   logic [SUB_W-1:0]  sub_r, sub_nxt_s;
   logic [DIV_W-1:0]  act_int_r, act_int_nxt_s;
   logic [DIV_W-1:0]  shd_int_r, shd_int_nxt_s;
   logic              pend_r, pend_nxt_s;
   logic [DIV_W-1:0]  new_int_s;
   logic [PW-1:0]     period_s;
   logic              wrap_s;
   logic              apply_s;

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] acc_r, acc_nxt_s;
   logic              carry_r, carry_nxt_s;
   logic [FRAC_W-1:0] act_frac_r, act_frac_nxt_s;
   logic [FRAC_W-1:0] shd_frac_r, shd_frac_nxt_s;
   logic [FRAC_W-1:0] new_frac_s;
`else
   logic              unused_frac_s;
   assign unused_frac_s = ^{div_frac_i, FRAC_W'(DEFAULT_FRAC)};
`endif

   // Current period length, boundary detection and divisor-apply decision.
   always_comb begin
      period_s  = {1'b0, act_int_r};
      new_int_s = shd_int_r;
`ifdef UART_BAUD_FRAC_EN
      new_frac_s = shd_frac_r;
      // A carry from the previous boundary stretches this period by one cycle.
      if (carry_r) begin
         period_s = {1'b0, act_int_r} + PW'(1);
      end else begin
         period_s = {1'b0, act_int_r};
      end
`endif
      // ">=" rather than "==" so a divisor shrunk while frozen cannot run away.
      wrap_s  = en_i & ~resync_i & (({1'b0, cnt_r} + PW'(1)) >= period_s);
      apply_s = (pend_r | div_load_i) & (wrap_s | ~en_i | resync_i);
      // A load in the apply cycle is newer than anything in the shadow.
      if (div_load_i) begin
         new_int_s = div_int_i;
`ifdef UART_BAUD_FRAC_EN
         new_frac_s = div_frac_i;
`endif
      end else begin
         new_int_s = shd_int_r;
      end
   end

   // Next-state values for counters, accumulator and divisor registers.
   always_comb begin
      cnt_nxt_s     = cnt_r;
      sub_nxt_s     = sub_r;
      act_int_nxt_s = act_int_r;
      shd_int_nxt_s = shd_int_r;
      pend_nxt_s    = pend_r;
`ifdef UART_BAUD_FRAC_EN
      acc_nxt_s      = acc_r;
      carry_nxt_s    = carry_r;
      act_frac_nxt_s = act_frac_r;
      shd_frac_nxt_s = shd_frac_r;
`endif
      if (resync_i) begin
         cnt_nxt_s = {DIV_W{1'b0}};
         sub_nxt_s = {SUB_W{1'b0}};
      end else if (wrap_s) begin
         cnt_nxt_s = {DIV_W{1'b0}};
         sub_nxt_s = sub_r + SUB_W'(1);
      end else if (en_i) begin
         cnt_nxt_s = cnt_r + DIV_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
`ifdef UART_BAUD_FRAC_EN
      // A fresh divisor or phase starts the fractional sequence from zero.
      if (resync_i || apply_s) begin
         acc_nxt_s   = {FRAC_W{1'b0}};
         carry_nxt_s = 1'b0;
      end else if (wrap_s) begin
         {carry_nxt_s, acc_nxt_s} = {1'b0, acc_r} + {1'b0, act_frac_r};
      end else begin
         acc_nxt_s   = acc_r;
         carry_nxt_s = carry_r;
      end
`endif
      if (apply_s) begin
         act_int_nxt_s = clamp_div(new_int_s);
         pend_nxt_s    = 1'b0;
`ifdef UART_BAUD_FRAC_EN
         act_frac_nxt_s = new_frac_s;
`endif
      end else if (div_load_i) begin
         shd_int_nxt_s = div_int_i;
         pend_nxt_s    = 1'b1;
`ifdef UART_BAUD_FRAC_EN
         shd_frac_nxt_s = div_frac_i;
`endif
      end else begin
         pend_nxt_s = pend_r;
      end
   end

   // State and registered strobe outputs.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         cnt_r     <= {DIV_W{1'b0}};
         sub_r     <= {SUB_W{1'b0}};
         act_int_r <= clamp_div(DIV_W'(DEFAULT_INT));
         shd_int_r <= {DIV_W{1'b0}};
         pend_r    <= 1'b0;
         div_ack_o <= 1'b0;
         tick16_o  <= 1'b0;
         tick_o    <= 1'b0;
         mid_o     <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
         acc_r      <= {FRAC_W{1'b0}};
         carry_r    <= 1'b0;
         act_frac_r <= FRAC_W'(DEFAULT_FRAC);
         shd_frac_r <= {FRAC_W{1'b0}};
`endif
      end else begin
         cnt_r     <= cnt_nxt_s;
         sub_r     <= sub_nxt_s;
         act_int_r <= act_int_nxt_s;
         shd_int_r <= shd_int_nxt_s;
         pend_r    <= pend_nxt_s;
         div_ack_o <= apply_s;
         tick16_o  <= wrap_s;
         tick_o    <= wrap_s & (sub_r == SUB_LAST);
         mid_o     <= wrap_s & (sub_r == SUB_MID);
`ifdef UART_BAUD_FRAC_EN
         acc_r      <= acc_nxt_s;
         carry_r    <= carry_nxt_s;
         act_frac_r <= act_frac_nxt_s;
         shd_frac_r <= shd_frac_nxt_s;
`endif
      end
   end

endmodule
